// File: rtl/pipe_pkg.sv
// pipe_pkg: opcodes, instruction field positions and
// hazard-controller state encoding shared by the pipeline.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_MUL   = 6'h1C;
  localparam logic [5:0] OP_DIV   = 6'h1D;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_mc(input logic [5:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: load-use compare between the load in EXE
// and the source registers of the instruction in ID.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic [IW-1:0] id_inst,
  input  logic          id_valid,
  input  logic [IW-1:0] exe_inst,
  input  logic          exe_valid,
  output logic          lu_hazard
);

  logic [5:0] id_op;
  logic [5:0] exe_op;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] exe_rt;
  logic       rs_hit;
  logic       rt_hit;

  assign id_op  = id_inst[OP_MSB:OP_LSB];
  assign id_rs  = id_inst[RS_MSB:RS_LSB];
  assign id_rt  = id_inst[RT_MSB:RT_LSB];
  assign exe_op = exe_inst[OP_MSB:OP_LSB];
  assign exe_rt = exe_inst[RT_MSB:RT_LSB];

  assign rs_hit = (exe_rt == id_rs);
  assign rt_hit = uses_rt(id_op) && (exe_rt == id_rt);

  // r0 is hardwired zero, so a load into it never creates a dependency
  assign lu_hazard = exe_valid && id_valid &&
                     (exe_op == OP_LW) && (exe_rt != 5'd0) &&
                     (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/bubble sequencing for the
// 5-stage pipeline plus a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int IW        = 32,
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IW-1:0]    id_inst,
  input  logic             id_valid,
  input  logic [IW-1:0]    exe_inst,
  input  logic             exe_valid,
  input  logic             exe_br_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idexe_en,
  output logic             idexe_bubble,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [3:0]       MC_INIT = 4'(MC_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       lu_hazard;
  logic       br_ev;
  logic       mc_ev;
  logic       mc_hold;

  hazard_detect #(
    .IW(IW)
  ) u_hd (
    .id_inst   (id_inst),
    .id_valid  (id_valid),
    .exe_inst  (exe_inst),
    .exe_valid (exe_valid),
    .lu_hazard (lu_hazard)
  );

  assign br_ev = exe_valid && exe_br_taken;
  assign mc_ev = exe_valid && is_mc(exe_inst[OP_MSB:OP_LSB]);

  // the start cycle and every MC_WAIT cycle with cnt!=0 freeze the front end
  assign mc_hold = (state == MC_WAIT) ? (cnt != 4'd0) : (!br_ev && mc_ev);

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: enter MC_WAIT on a MUL/DIV, count down, then release
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (!br_ev && mc_ev) begin
          state_nxt = MC_WAIT;
          cnt_nxt   = MC_INIT;
        end
      end
      MC_WAIT: begin
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        else state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Outputs: reset bubbles, then MC hold, then branch > load-use
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idexe_en     = 1'b1;
    idexe_bubble = 1'b0;
    mc_busy      = 1'b0;
    priority case (1'b1)
      !rst_n: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b1;
        idexe_bubble = 1'b1;
      end
      mc_hold: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idexe_en = 1'b0;
        mc_busy  = 1'b1;
      end
      (state == MC_WAIT): begin
      end
      br_ev: begin
        ifid_flush   = 1'b1;
        idexe_bubble = 1'b1;
      end
      lu_hazard: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idexe_bubble = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Saturating count of cycles where the PC was held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (!pc_en && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table, saturation run and
// randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int MC = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  localparam logic [5:0] OP_ADDI = 6'h08;

  // {pc_en, ifid_en, ifid_flush, idexe_en, idexe_bubble, mc_busy}
  localparam logic [5:0] O_RUN = 6'b110100;
  localparam logic [5:0] O_LU  = 6'b000110;
  localparam logic [5:0] O_MC  = 6'b000001;
  localparam logic [5:0] O_BR  = 6'b111110;
  localparam logic [5:0] O_RST = 6'b001110;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   id_inst = '0;
  logic          id_valid = 1'b0;
  logic [31:0]   exe_inst = '0;
  logic          exe_valid = 1'b0;
  logic          exe_br_taken = 1'b0;
  logic          pc_en;
  logic          ifid_en;
  logic          ifid_flush;
  logic          idexe_en;
  logic          idexe_bubble;
  logic          mc_busy;
  logic [CW-1:0] stall_cycles;
  logic [5:0]    outs;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .IW(32), .MC_CYCLES(MC), .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_inst      (id_inst),
    .id_valid     (id_valid),
    .exe_inst     (exe_inst),
    .exe_valid    (exe_valid),
    .exe_br_taken (exe_br_taken),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idexe_en     (idexe_en),
    .idexe_bubble (idexe_bubble),
    .mc_busy      (mc_busy),
    .stall_cycles (stall_cycles)
  );

  assign outs = {pc_en, ifid_en, ifid_flush,
                 idexe_en, idexe_bubble, mc_busy};

  typedef struct {
    logic        rst;
    logic [31:0] id;
    logic        idv;
    logic [31:0] exe;
    logic        exv;
    logic        br;
    logic [5:0]  eo;
    int          ec;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
    return {op, rs, rt, 16'h0};
  endfunction

  task automatic drive(input logic r, input logic [31:0] id,
                       input logic iv, input logic [31:0] ex,
                       input logic ev, input logic b);
    @(posedge clk);
    #1;
    rst_n = r;
    id_inst = id;
    id_valid = iv;
    exe_inst = ex;
    exe_valid = ev;
    exe_br_taken = b;
    #3;
  endtask

  // reference: age = cycles the MUL/DIV has spent in EXE (0 = none)
  function automatic logic [5:0] model_out(
      input logic r, input logic [31:0] id, input logic iv,
      input logic [31:0] ex, input logic ev, input logic b,
      input int age);
    logic [4:0] xrt;
    logic [5:0] iop;
    logic lu;
    xrt = ex[20:16];
    iop = id[31:26];
    lu = ev && iv && (ex[31:26] == OP_LW) && (xrt != 0) &&
         ((xrt == id[25:21]) ||
          ((iop == OP_RTYPE || iop == OP_SW || iop == OP_BEQ ||
            iop == OP_BNE) && xrt == id[20:16]));
    if (!r) return O_RST;
    if (age > 0) return (age < MC) ? O_MC : O_RUN;
    if (ev && b) return O_BR;
    if (ev && (ex[31:26] == OP_MUL || ex[31:26] == OP_DIV)) return O_MC;
    if (lu) return O_LU;
    return O_RUN;
  endfunction

  initial begin
    vec_t vecs[$];
    logic [31:0] lw5, add5, mul, nop;
    logic [5:0] ops[8];
    logic [5:0] eo;
    int age;
    int mcnt;

    lw5  = mk(OP_LW, 5'd1, 5'd5);
    add5 = mk(OP_RTYPE, 5'd5, 5'd6);
    mul  = mk(OP_MUL, 5'd2, 5'd3);
    nop  = 32'h0;

    vecs.push_back('{1'b0, add5, 1'b1, mul, 1'b1, 1'b1, O_RST, 0});
    vecs.push_back('{1'b0, add5, 1'b1, lw5, 1'b1, 1'b0, O_RST, 0});
    vecs.push_back('{1'b0, nop, 1'b0, nop, 1'b0, 1'b1, O_RST, 0});
    vecs.push_back('{1'b1, nop, 1'b1, nop, 1'b1, 1'b0, O_RUN, 0});
    vecs.push_back('{1'b1, add5, 1'b1, lw5, 1'b1, 1'b0, O_LU, 0});
    vecs.push_back('{1'b1, add5, 1'b1, nop, 1'b0, 1'b0, O_RUN, 1});
    vecs.push_back('{1'b1, mk(OP_RTYPE, 5'd0, 5'd6), 1'b1,
                     mk(OP_LW, 5'd1, 5'd0), 1'b1, 1'b0, O_RUN, 1});
    vecs.push_back('{1'b1, mk(OP_ADDI, 5'd1, 5'd5), 1'b1,
                     lw5, 1'b1, 1'b0, O_RUN, 1});
    vecs.push_back('{1'b1, add5, 1'b1, mul, 1'b1, 1'b0, O_MC, 1});
    vecs.push_back('{1'b1, add5, 1'b1, mul, 1'b1, 1'b0, O_MC, 2});
    vecs.push_back('{1'b1, add5, 1'b1, mul, 1'b1, 1'b0, O_MC, 3});
    vecs.push_back('{1'b1, add5, 1'b1, mul, 1'b1, 1'b1, O_RUN, 4});
    vecs.push_back('{1'b1, nop, 1'b1, nop, 1'b1, 1'b0, O_RUN, 4});
    vecs.push_back('{1'b1, add5, 1'b1, mk(OP_BEQ, 5'd1, 5'd5),
                     1'b1, 1'b1, O_BR, 4});
    vecs.push_back('{1'b1, add5, 1'b1, lw5, 1'b1, 1'b1, O_BR, 4});
    vecs.push_back('{1'b1, add5, 1'b1, mul, 1'b1, 1'b1, O_BR, 4});
    vecs.push_back('{1'b1, add5, 1'b1, mul, 1'b1, 1'b0, O_MC, 4});
    vecs.push_back('{1'b0, add5, 1'b1, mul, 1'b1, 1'b0, O_RST, 5});
    vecs.push_back('{1'b1, nop, 1'b0, nop, 1'b0, 1'b0, O_RUN, 0});
    vecs.push_back('{1'b1, nop, 1'b0, nop, 1'b0, 1'b0, O_RUN, 0});
    vecs.push_back('{1'b1, add5, 1'b1, mul, 1'b0, 1'b0, O_RUN, 0});
    vecs.push_back('{1'b1, add5, 1'b1, lw5, 1'b0, 1'b1, O_RUN, 0});
    vecs.push_back('{1'b1, mk(OP_SW, 5'd1, 5'd5), 1'b1,
                     lw5, 1'b1, 1'b0, O_LU, 0});
    vecs.push_back('{1'b1, mk(OP_BNE, 5'd2, 5'd5), 1'b1,
                     lw5, 1'b1, 1'b0, O_LU, 1});
    vecs.push_back('{1'b1, add5, 1'b0, lw5, 1'b1, 1'b0, O_RUN, 2});

    @(posedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].id, vecs[i].idv,
            vecs[i].exe, vecs[i].exv, vecs[i].br);
      check($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].eo));
      check($sformatf("vec%0d_stall", i), 32'(stall_cycles),
            32'(vecs[i].ec));
    end

    drive(1'b0, nop, 1'b0, nop, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, add5, 1'b1, lw5, 1'b1, 1'b0);
      check($sformatf("sat%0d_outs", i), 32'(outs), 32'(O_LU));
      check($sformatf("sat%0d_stall", i), 32'(stall_cycles),
            32'((i < SAT) ? i : SAT));
    end
    drive(1'b1, nop, 1'b1, nop, 1'b1, 1'b0);
    check("sat_hold", 32'(stall_cycles), 32'(SAT));

    ops = '{OP_RTYPE, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_MUL, OP_DIV, OP_ADDI};
    drive(1'b0, nop, 1'b0, nop, 1'b0, 1'b0);
    age = 0;
    mcnt = 0;
    for (int i = 0; i < 1500; i++) begin
      logic r, iv, ev, b;
      logic [31:0] id, ex;
      r  = (i == 0) ? 1'b1 : ($urandom_range(0, 59) != 0);
      id = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)));
      ex = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)));
      iv = ($urandom_range(0, 4) != 0);
      ev = ($urandom_range(0, 4) != 0);
      b  = ($urandom_range(0, 6) == 0);
      drive(r, id, iv, ex, ev, b);
      eo = model_out(r, id, iv, ex, ev, b, age);
      check($sformatf("rnd%0d_outs", i), 32'(outs), 32'(eo));
      check($sformatf("rnd%0d_stall", i), 32'(stall_cycles), 32'(mcnt));
      if (!r) begin
        age = 0;
        mcnt = 0;
      end else begin
        if (!eo[5] && mcnt < SAT) mcnt++;
        if (age > 0) age = (age < MC) ? age + 1 : 0;
        else if (eo == O_MC) age = 2;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage 32-bit RISC pipeline. It inspects the instructions in the ID and EXE stages each cycle. It drives enable, flush and bubble controls for the PC, the IF/ID register and the ID/EXE register. It handles three cases: load-use stalls, taken-branch flushes and multi-cycle EXE operations (MUL/DIV). It also keeps a saturating stall-cycle counter.

Parameters:
IW, 32, instruction width
MC_CYCLES, 4, total cycles a MUL/DIV occupies EXE; legal range 2..16
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  synchronous active-low reset
id_inst  in  IW  instruction in ID stage (IF/ID output)
id_valid  in  1  ID stage holds a real instruction
exe_inst  in  IW  instruction in EXE stage (ID/EXE out_inst)
exe_valid  in  1  EXE stage holds a real instruction
exe_br_taken  in  1  branch in EXE resolved taken this cycle
pc_en  out  1  PC may update
ifid_en  out  1  IF/ID may load
ifid_flush  out  1  IF/ID loads a NOP/invalid instead of fetched word
idexe_en  out  1  ID/EXE may load
idexe_bubble  out  1  ID/EXE loads a NOP/invalid instead of ID output
mc_busy  out  1  multi-cycle op stalling EXE
stall_cycles  out  CNT_W  count of cycles with pc_en=0, saturating

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. All state updates occur on the rising edge of clk.
- Field decode:
  - opcode = inst[31:26]
  - rs = inst[25:21]
  - rt = inst[20:16]
- Outputs pc_en..mc_busy are combinational from the registered state and current inputs. stall_cycles is registered.
- State machine states are RUN and MC_WAIT. State registers are state and cnt (4 bit).
- Reset (rst_n=0 at edge): state<=RUN, cnt<=0, stall_cycles<=0.
  - While rst_n=0, outputs are pc_en=0, ifid_en=0, ifid_flush=1, idexe_en=1, idexe_bubble=1, mc_busy=0.
  - This forces bubbles into the pipeline.
  - Reset mid-MC_WAIT aborts to RUN.
- Default in RUN: pc_en=ifid_en=idexe_en=1; flush, bubble and mc_busy are 0.
- Priority per cycle: branch flush > multi-cycle start > load-use stall.
- Branch flush (RUN, exe_valid & exe_br_taken):
  - Outputs: ifid_flush=1, idexe_bubble=1, pc_en=1 so the PC loads the target.
  - Penalty is exactly 1 cycle; there is no state change.
- Multi-cycle start (RUN, exe_valid & exe opcode in {OP_MUL, OP_DIV}):
  - Outputs: pc_en=ifid_en=idexe_en=0, mc_busy=1.
  - Registered update: cnt<=MC_CYCLES-2, state<=MC_WAIT.
- MC_WAIT with cnt!=0: hold everything (same outputs as the start cycle); cnt<=cnt-1.
- MC_WAIT with cnt==0:
  - Release cycle: all enables 1, mc_busy=0; state<=RUN.
  - The MUL/DIV advances out of EXE on this edge, so it occupies EXE for exactly MC_CYCLES cycles.
  - Load-use and branch checks are not evaluated in MC_WAIT.
- Load-use (RUN, no higher-priority event, exe_valid & id_valid & exe opcode==OP_LW & exe.rt!=0):
  - Hazard condition: exe.rt==id.rs, or (id uses rt & exe.rt==id.rt).
  - "id uses rt" means id opcode is in {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE}.
  - Outputs: pc_en=0, ifid_en=0, idexe_bubble=1, idexe_en=1.
  - This inserts a 1-cycle bubble; the condition clears naturally the next cycle.
- Register 0 never causes a hazard.
- Invalid (exe_valid=0) EXE never triggers any event.
- stall_cycles increments by 1 on each edge where rst_n=1 and pc_en=0. It holds at 2^CNT_W-1.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants: OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_BNE=6'h05, OP_LW=6'h23, OP_SW=6'h2B, OP_MUL=6'h1C, OP_DIV=6'h1D
  - field position constants
  - state encoding RUN=1'b0, MC_WAIT=1'b1
- One natural sub-module: hazard_detect, the pure combinational load-use compare (inputs id_inst, exe_inst and valids; output lu_hazard). The FSM, counter and output muxing stay in pipe_hazard_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with arbitrary inputs. Required: pc_en=0, ifid_flush=1, idexe_bubble=1, stall_cycles=0. After release with NOP traffic, all enables are 1.
- Load-use: EXE=LW rt=5, ID=ADD (R-type) rs=5. Required: exactly 1 cycle of pc_en=0, ifid_en=0, idexe_bubble=1, and stall_cycles +1. Repeat with rt=0: no stall. Repeat with ID=ADDI rt=5 (I-type, rt not used): no stall.
- Multi-cycle: EXE=MUL valid with MC_CYCLES=4. Required: pc_en=idexe_en=0 and mc_busy=1 for 3 cycles, then 1 release cycle with enables=1, then RUN. stall_cycles increases by 3.
- Branch: exe_br_taken=1 with exe_valid=1 while EXE=BEQ, and an ID load-use match present. Required: ifid_flush=1, idexe_bubble=1, pc_en=1 for 1 cycle, and no stall (branch priority).
- Reset mid-MC_WAIT: assert rst_n=0 one cycle after MUL start. Required: state returns to RUN and stall_cycles=0. After reset, idle inputs give no residual stall.
- Saturation: CNT_W=4 with back-to-back load-use stalls for 20 cycles. Required: stall_cycles stops at 15.
